mem_access_unit: RTL

Memory-access stage controller for the pipelined RISC-V core. It sits between the EX/MEM pipeline register and the data memory. It turns one load or store per instruction into a single word-aligned data-memory transaction with byte enables, and stalls the pipeline until the memory acknowledges. Load data is returned with the addressed byte or halfword shifted down to bit 0, so the downstream load sign/zero-extension stage works only on the low lanes.

---
 rtl/mem_access_unit_pkg.sv | 16 +
 rtl/mem_access_unit_if.sv | 14 +
 rtl/mem_access_unit_store_lane_align.sv | 19 +
 rtl/mem_access_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: funct3 access codes and FSM state encoding shared by the memory-access stage
package mem_access_unit_pkg;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory bus; master issues req/we/addr/be/wdata, slave returns ack/rdata
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;
  modport master(output req, we, addr, be, wdata, input ack, rdata);
  modport slave(input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_store_lane_align.sv
// mem_access_unit_store_lane_align: size (funct3[1:0]) + byte offset -> byte enables, replicated store data, misalignment
// Ports: size, off, store_data in; be, wdata, misaligned out. Purely combinational.
module mem_access_unit_store_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);
  always_comb begin
    be = size == F3_SB[1:0] ? 4'b0001 << off : size == F3_SH[1:0] ? 4'b0011 << off : 4'b1111;
    wdata = size == F3_SB[1:0] ? {4{store_data[7:0]}} :
            size == F3_SH[1:0] ? {2{store_data[15:0]}} : store_data;
    misaligned = size == F3_SH[1:0] ? off[0] : size == F3_SW[1:0] ? |off : 1'b0;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller turning one load/store into a word-aligned dmem transaction
// Ports: clk, rst (async active-low); pipeline request mem_valid/mem_read/mem_write/funct3/addr/store_data;
// stall, load_data, load_valid, access_fault back to the pipeline; dmem master bus via mem_access_unit_if.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              access_fault,
  mem_access_unit_if.master dmem
);
  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata, shifted;
  logic              misaligned, bad_f3, illegal, fire, start, capture;
  mem_access_unit_store_lane_align u_store_lane_align (
    .size      (funct3[1:0]),
    .off       (addr[1:0]),
    .store_data(store_data),
    .be        (st_be),
    .wdata     (st_wdata),
    .misaligned(misaligned)
  );
  always_comb begin
    bad_f3 = mem_write ? funct3 > F3_SW : !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    illegal = (mem_read && mem_write) || bad_f3 || misaligned;
    fire = state_q == IDLE && mem_valid && (mem_read || mem_write);
    start = fire && !illegal;
    // rst gating keeps these combinational outputs quiet while held in reset
    access_fault = rst && fire && illegal;
    stall = rst && (start || state_q == BUSY);
    capture = state_q == BUSY && dmem.ack && !we_q;
    shifted = dmem.rdata >> {off_q, 3'b000};
    state_d = start ? BUSY : state_q == BUSY ? (dmem.ack ? DONE : BUSY) : IDLE;
    we_d = start ? mem_write : we_q;
    addr_d = start ? {addr[ADDR_W-1:2], 2'b00} : addr_q;
    be_d = start ? (mem_write ? st_be : 4'b1111) : be_q;
    wdata_d = start ? (mem_write ? st_wdata : 32'h0) : wdata_q;
    size_d = start ? funct3[1:0] : size_q;
    off_d = start ? addr[1:0] : off_q;
    load_data_d = !capture ? load_data_q :
                  size_q == F3_LB[1:0] ? {24'h0, shifted[7:0]} :
                  size_q == F3_LH[1:0] ? {16'h0, shifted[15:0]} : shifted;
    load_valid_d = capture;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      size_q       <= 2'd0;
      off_q        <= 2'd0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      off_q        <= off_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
    end
  end
  assign dmem.req   = state_q == BUSY;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
endmodule
